// File: rtl/cpu_pkg.sv
// Shared CPU constants, datapath types and ALU opcode encodings.
// Used by the register file, the decoder and the ALU.
package cpu_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = 3;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [AW-1:0]    reg_addr_t;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpShl = 3'd5,
    OpShr = 3'd6
  } alu_op_e;

  function automatic logic is_zero(input word_t w);
    return (w == '0);
  endfunction

endpackage

// File: rtl/flag_reg.sv
// Carry/zero flags register; zero resets high because the reset state reads as zero.
module flag_reg #(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flags_we,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] wr_data,
  output logic             carry_flag,
  output logic             zero_flag
);

  logic carry_q, carry_d;
  logic zero_q, zero_d;

  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (flags_we) begin
      carry_d = carry_in;
      zero_d  = (wr_data == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;

endmodule

// File: rtl/alu_regfile.sv
// Register file with registered, write-bypassed operand reads plus the flags register.
// Define ALU_REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module alu_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH,
  parameter int unsigned NREGS = cpu_pkg::NREGS,
  parameter int unsigned AW    = cpu_pkg::AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] operand1,
  output logic [WIDTH-1:0] operand2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             flags_we,
  input  logic             carry_in,
  output logic             carry_flag,
  output logic             zero_flag
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             wr_fire;

`ifdef ALU_REGFILE_R0_ZERO_EN
  assign wr_fire = wr_en && (wr_addr != '0);
`else
  assign wr_fire = wr_en;
`endif

  // Reads index the post-write array, which gives the write-to-read bypass for free.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr,
                                                 input logic [WIDTH-1:0] arr [NREGS]);
`ifdef ALU_REGFILE_R0_ZERO_EN
    if (addr == '0) return '0;
`endif
    return arr[addr];
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wr_fire) regs_d[wr_addr] = wr_data;
    op1_d = op1_q;
    op2_d = op2_q;
    if (rd_en) begin
      op1_d = read_port(rd_addr_a, regs_d);
      op2_d = read_port(rd_addr_b, regs_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      op1_q <= '0;
      op2_q <= '0;
    end else begin
      regs_q <= regs_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
    end
  end

  assign operand1 = op1_q;
  assign operand2 = op2_q;

  flag_reg #(
    .WIDTH(WIDTH)
  ) u_flag_reg (
    .clk       (clk),
    .reset     (reset),
    .flags_we  (flags_we),
    .carry_in  (carry_in),
    .wr_data   (wr_data),
    .carry_flag(carry_flag),
    .zero_flag (zero_flag)
  );

endmodule

// File: tb/tb_alu_regfile.sv
// Directed + random bench for alu_regfile against a behavioural array model.
module tb_alu_regfile;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_addr_a = '0;
  logic [2:0] rd_addr_b = '0;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       flags_we = 1'b0;
  logic       carry_in = 1'b0;
  logic       carry_flag;
  logic       zero_flag;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0] m_regs [8];
  logic [7:0] m_op1, m_op2;
  logic       m_c, m_z;

  always #5 clk = ~clk;

  alu_regfile u_dut (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .operand1  (operand1),
    .operand2  (operand2),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .flags_we  (flags_we),
    .carry_in  (carry_in),
    .carry_flag(carry_flag),
    .zero_flag (zero_flag)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".op1"}, operand1, m_op1);
    check({tag, ".op2"}, operand2, m_op2);
    check({tag, ".carry"}, {7'd0, carry_flag}, {7'd0, m_c});
    check({tag, ".zero"}, {7'd0, zero_flag}, {7'd0, m_z});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_op1 = 8'h00;
    m_op2 = 8'h00;
    m_c   = 1'b0;
    m_z   = 1'b1;
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a);
`ifdef ALU_REGFILE_R0_ZERO_EN
    if (a == 3'd0) return 8'h00;
`endif
    return m_regs[a];
  endfunction

  // Architectural meaning of one clock edge: write lands, then reads see the new state.
  task automatic model_edge();
    bit r0_blocked = 1'b0;
`ifdef ALU_REGFILE_R0_ZERO_EN
    r0_blocked = (wr_addr == 3'd0);
`endif
    if (wr_en && !r0_blocked) m_regs[wr_addr] = wr_data;
    if (rd_en) begin
      m_op1 = model_read(rd_addr_a);
      m_op2 = model_read(rd_addr_b);
    end
    if (flags_we) begin
      m_c = carry_in;
      m_z = (wr_data == 8'h00);
    end
  endtask

  // Drive one cycle of inputs 1 time unit after an edge, clock it, then check.
  task automatic step(input string tag, input logic re, input logic [2:0] a, input logic [2:0] b,
                      input logic we, input logic [2:0] wa, input logic [7:0] wd,
                      input logic fwe, input logic cin);
    rd_en = re; rd_addr_a = a; rd_addr_b = b;
    wr_en = we; wr_addr = wa; wr_data = wd;
    flags_we = fwe; carry_in = cin;
    @(posedge clk);
    #1;
    model_edge();
    check_model(tag);
  endtask

  initial begin
    model_reset();
    // Asynchronous reset mid-cycle, checked before any clock edge.
    #3 reset = 1'b1;
    #1;
    check("rst.op1", operand1, 8'h00);
    check("rst.op2", operand2, 8'h00);
    check("rst.carry", {7'd0, carry_flag}, 8'h00);
    check("rst.zero", {7'd0, zero_flag}, 8'h01);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    step("wr_r1", 0, 0, 0, 1, 3'd1, 8'h0D, 0, 0);
    step("wr_r2", 0, 0, 0, 1, 3'd2, 8'h03, 0, 0);
    step("rd_r1r2", 1, 3'd1, 3'd2, 0, 0, 8'h00, 0, 0);
    check("rd_r1", operand1, 8'h0D);
    check("rd_r2", operand2, 8'h03);

    step("bypass", 1, 3'd5, 3'd5, 1, 3'd5, 8'hA5, 0, 0);
    check("byp_a", operand1, 8'hA5);
    check("byp_b", operand2, 8'hA5);

    step("hold", 0, 3'd1, 3'd1, 1, 3'd1, 8'hFF, 0, 0);
    check("hold_a", operand1, 8'hA5);
    step("rd_r1_new", 1, 3'd1, 3'd2, 0, 0, 8'h00, 0, 0);
    check("r1_ff", operand1, 8'hFF);

    step("flag_set", 0, 0, 0, 0, 0, 8'h00, 1, 1);
    check("fs_c", {7'd0, carry_flag}, 8'h01);
    check("fs_z", {7'd0, zero_flag}, 8'h01);
    step("flag_clr", 0, 0, 0, 0, 0, 8'h10, 1, 0);
    check("fc_c", {7'd0, carry_flag}, 8'h00);
    check("fc_z", {7'd0, zero_flag}, 8'h00);
    step("flag_hold", 0, 0, 0, 1, 3'd3, 8'h00, 0, 1);
    check("fh_c", {7'd0, carry_flag}, 8'h00);
    check("fh_z", {7'd0, zero_flag}, 8'h00);

    step("r0_same", 1, 3'd0, 3'd1, 1, 3'd0, 8'h55, 0, 0);
    step("r0_next", 1, 3'd0, 3'd0, 0, 0, 8'h00, 0, 0);
`ifdef ALU_REGFILE_R0_ZERO_EN
    check("r0_hardwired", operand1, 8'h00);
`else
    check("r0_plain", operand1, 8'h55);
`endif

    // Reset during a pending write: the write must be discarded.
    rd_en = 0; wr_en = 1; wr_addr = 3'd4; wr_data = 8'h77; flags_we = 1; carry_in = 1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_model("rst_mid");
    @(posedge clk);
    #3 reset = 1'b0;
    step("rst_rd_r4", 1, 3'd4, 3'd1, 0, 0, 8'h00, 0, 0);
    check("r4_cleared", operand1, 8'h00);

    for (int i = 0; i < 150; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
           (($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom)), 1'($urandom),
           1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
